// File: rtl/rsa_cmd_ctrl.sv
// rtl/rsa_cmd_ctrl.sv - ARM command/data responder for the RSA exponentiation core
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   arm_to_fpga_cmd[_valid]      32-bit command {t[31:22], opcode[21:0]}, sampled in IDLE only
//   arm_to_fpga_done[_read]      completion flag, held until acknowledged
//   arm_to_fpga_data[_valid]     operand input; arm_to_fpga_data_ready is a one-cycle accept pulse
//   fpga_to_arm_data[_valid]     result/readback output; transfer on valid & fpga_to_arm_data_ready
//   core_x/e/m/r/r2, core_t      operand registers and exponent bit count presented to the core
//   core_start, core_done        one-cycle start pulse; core_result valid while core_done is high
//   leds                         {error flag, state[2:0]}
//
// Optional feature macro: RSA_READBACK_EN (opcodes 4/6/8/10/12 return X/E/M/R/R2).
module rsa_cmd_ctrl #(
    parameter int DATA_W = 1024,
    parameter int T_W    = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       arm_to_fpga_cmd,
    input  logic              arm_to_fpga_cmd_valid,
    output logic              arm_to_fpga_done,
    input  logic              arm_to_fpga_done_read,
    input  logic              arm_to_fpga_data_valid,
    output logic              arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0] arm_to_fpga_data,
    output logic              fpga_to_arm_data_valid,
    input  logic              fpga_to_arm_data_ready,
    output logic [DATA_W-1:0] fpga_to_arm_data,
    output logic [DATA_W-1:0] core_x,
    output logic [DATA_W-1:0] core_e,
    output logic [DATA_W-1:0] core_m,
    output logic [DATA_W-1:0] core_r,
    output logic [DATA_W-1:0] core_r2,
    output logic [T_W-1:0]    core_t,
    output logic              core_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic [3:0]        leds
);

    localparam int OP_W = 32 - T_W;

    localparam logic [OP_W-1:0] OP_COMPUTE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LD_X    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_WRITE   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LD_E    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LD_R    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LD_R2   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LD_M    = OP_W'(9);
`ifdef RSA_READBACK_EN
    localparam logic [OP_W-1:0] OP_RD_X    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_RD_E    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_RD_M    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_RD_R    = OP_W'(10);
    localparam logic [OP_W-1:0] OP_RD_R2   = OP_W'(12);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX    = 3'd1,
        S_RUN   = 3'd2,
        S_WAITC = 3'd3,
        S_TX    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef enum logic [2:0] {K_COMPUTE, K_LOAD, K_WRITE, K_READ, K_UNKNOWN} kind_t;

    function automatic kind_t decode(input logic [OP_W-1:0] op);
        case (op)
            OP_COMPUTE:                                  return K_COMPUTE;
            OP_LD_X, OP_LD_E, OP_LD_R, OP_LD_R2, OP_LD_M: return K_LOAD;
            OP_WRITE:                                    return K_WRITE;
`ifdef RSA_READBACK_EN
            OP_RD_X, OP_RD_E, OP_RD_M, OP_RD_R, OP_RD_R2: return K_READ;
`endif
            default:                                     return K_UNKNOWN;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [31:0]         cmd_q;
    logic [DATA_W-1:0]   result_q;
    logic                err_q;
    logic [DATA_W-1:0]   tx_data;

    wire [OP_W-1:0] op_q  = cmd_q[OP_W-1:0];
    wire [T_W-1:0]  run_t = cmd_q[31 -: T_W];

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (arm_to_fpga_cmd_valid) begin
                case (decode(arm_to_fpga_cmd[OP_W-1:0]))
                    K_COMPUTE:       state_d = S_RUN;
                    K_LOAD:          state_d = S_RX;
                    K_WRITE, K_READ: state_d = S_TX;
                    default:         state_d = S_DONE;
                endcase
            end
            S_RX:    if (arm_to_fpga_data_valid) state_d = S_DONE;
            S_RUN:   state_d = (run_t == '0) ? S_DONE : S_WAITC;
            S_WAITC: if (core_done) state_d = S_DONE;
            S_TX:    if (fpga_to_arm_data_ready) state_d = S_DONE;
            S_DONE:  if (arm_to_fpga_done_read) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers; data_ready and core_start are registered single-cycle pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_q                  <= '0;
            err_q                  <= 1'b0;
            result_q               <= '0;
            core_x                 <= '0;
            core_e                 <= '0;
            core_m                 <= '0;
            core_r                 <= '0;
            core_r2                <= '0;
            core_t                 <= '0;
            core_start             <= 1'b0;
            arm_to_fpga_data_ready <= 1'b0;
        end else begin
            core_start             <= 1'b0;
            arm_to_fpga_data_ready <= 1'b0;
            case (state_q)
                S_IDLE: if (arm_to_fpga_cmd_valid) begin
                    cmd_q <= arm_to_fpga_cmd;
                    err_q <= (decode(arm_to_fpga_cmd[OP_W-1:0]) == K_UNKNOWN);
                end
                S_RX: if (arm_to_fpga_data_valid) begin
                    arm_to_fpga_data_ready <= 1'b1;
                    case (op_q)
                        OP_LD_X:  core_x  <= arm_to_fpga_data;
                        OP_LD_E:  core_e  <= arm_to_fpga_data;
                        OP_LD_R:  core_r  <= arm_to_fpga_data;
                        OP_LD_R2: core_r2 <= arm_to_fpga_data;
                        OP_LD_M:  core_m  <= arm_to_fpga_data;
                        default:  ;
                    endcase
                end
                S_RUN: if (run_t != '0) begin
                    core_t     <= run_t;
                    core_start <= 1'b1;
                end
                S_WAITC: if (core_done) result_q <= core_result;
                default: ;
            endcase
        end
    end

    // Readback mux; without the feature only the result register can be sent
    always_comb begin
        tx_data = result_q;
`ifdef RSA_READBACK_EN
        case (op_q)
            OP_RD_X:  tx_data = core_x;
            OP_RD_E:  tx_data = core_e;
            OP_RD_M:  tx_data = core_m;
            OP_RD_R:  tx_data = core_r;
            OP_RD_R2: tx_data = core_r2;
            default:  tx_data = result_q;
        endcase
`endif
    end

    // Outputs decoded from state; data bus is zero outside TX
    always_comb begin
        arm_to_fpga_done       = (state_q == S_DONE);
        fpga_to_arm_data_valid = (state_q == S_TX);
        fpga_to_arm_data       = (state_q == S_TX) ? tx_data : '0;
        leds                   = {err_q, state_q};
    end

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// tb/tb_rsa_cmd_ctrl.sv - scoreboard testbench for rsa_cmd_ctrl
module tb_rsa_cmd_ctrl;

    localparam int DW = 1024;
    localparam int TW = 10;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   cmd = '0;
    logic          cmd_valid = 1'b0;
    logic          done;
    logic          done_read = 1'b0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [DW-1:0] data_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [DW-1:0] core_x, core_e, core_m, core_r, core_r2;
    logic [TW-1:0] core_t;
    logic          core_start;
    logic          core_done = 1'b0;
    logic [DW-1:0] core_result = '0;
    logic [3:0]    leds;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q[$];
    logic [TW-1:0] t_q[$];

    rsa_cmd_ctrl #(.DATA_W(DW), .T_W(TW)) dut (
        .clk(clk), .resetn(resetn),
        .arm_to_fpga_cmd(cmd), .arm_to_fpga_cmd_valid(cmd_valid),
        .arm_to_fpga_done(done), .arm_to_fpga_done_read(done_read),
        .arm_to_fpga_data_valid(data_valid), .arm_to_fpga_data_ready(data_ready),
        .arm_to_fpga_data(data_in),
        .fpga_to_arm_data_valid(out_valid), .fpga_to_arm_data_ready(out_ready),
        .fpga_to_arm_data(out_data),
        .core_x(core_x), .core_e(core_e), .core_m(core_m), .core_r(core_r), .core_r2(core_r2),
        .core_t(core_t), .core_start(core_start), .core_done(core_done),
        .core_result(core_result), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got[63:0]=%h expected[63:0]=%h (upper bits %s)", tag,
                      got[63:0], exp[63:0], (got[DW-1:64] === exp[DW-1:64]) ? "equal" : "differ");
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] seed);
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = seed ^ (32'h9e3779b9 * i);
        return v;
    endfunction

    task automatic send_cmd(input logic [31:0] c);
        @(negedge clk);
        cmd = c; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, output int cyc,
                             output bit saw_ready, output bit saw_valid);
        cyc = 0; saw_ready = data_ready; saw_valid = out_valid;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            saw_ready |= data_ready;
            saw_valid |= out_valid;
        end
        check({tag, "_done"}, DW'(done), DW'(1'b1));
        done_read = 1'b1;
        @(negedge clk);
        done_read = 1'b0;
        check({tag, "_done_clr"}, DW'(done), DW'(1'b0));
        check({tag, "_idle"}, DW'(leds[2:0]), DW'(3'd0));
    endtask

    task automatic load_op(input string tag, input logic [31:0] op, input logic [DW-1:0] d);
        int cyc; bit sr, sv;
        @(negedge clk);
        cmd = op; cmd_valid = 1'b1; data_valid = 1'b1; data_in = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_rdy_early"}, DW'(data_ready), DW'(1'b0));
        @(negedge clk);
        check({tag, "_rdy_pulse"}, DW'(data_ready), DW'(1'b1));
        @(negedge clk);
        check({tag, "_rdy_drop"}, DW'(data_ready), DW'(1'b0));
        data_valid = 1'b0;
        wait_done(tag, 4, cyc, sr, sv);
    endtask

    task automatic run_compute(input string tag, input logic [TW-1:0] t, input logic [DW-1:0] res);
        int cyc = 0; int cyc2; bit sr, sv;
        t_q.push_back(t);
        send_cmd({t, 22'd0});
        while (!core_start && cyc < 10) begin @(negedge clk); cyc++; end
        check({tag, "_start"}, DW'(core_start), DW'(1'b1));
        check({tag, "_core_t"}, DW'(core_t), (t_q.size() != 0) ? DW'(t_q.pop_front()) : DW'(11'h7ff));
        @(negedge clk);
        check({tag, "_start_pulse"}, DW'(core_start), DW'(1'b0));
        cmd = 32'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check({tag, "_cmd_ignored"}, DW'(leds[2:0]), DW'(3'd3));
        core_done = 1'b1; core_result = res;
        @(negedge clk);
        core_done = 1'b0; core_result = '0;
        wait_done(tag, 4, cyc2, sr, sv);
    endtask

    task automatic read_cmd(input string tag, input logic [31:0] c, input int hold);
        int cyc; bit sr, sv, stable;
        logic [DW-1:0] first, exp;
        out_ready = (hold == 0);
        send_cmd(c);
        first = out_data; stable = out_valid;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            stable &= out_valid & (out_data === first);
        end
        if (hold > 0) check({tag, "_hold_stable"}, DW'(stable), DW'(1'b1));
        out_ready = 1'b1;
        check({tag, "_valid"}, DW'(out_valid), DW'(1'b1));
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
        check({tag, "_data"}, out_data, exp);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, DW'(out_valid), DW'(1'b0));
        wait_done(tag, 4, cyc, sr, sv);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_done"}, DW'(done), DW'(1'b0));
        check({tag, "_ready"}, DW'(data_ready), DW'(1'b0));
        check({tag, "_ovalid"}, DW'(out_valid), DW'(1'b0));
        check({tag, "_odata"}, out_data, DW'(1'b0));
        check({tag, "_start"}, DW'(core_start), DW'(1'b0));
        check({tag, "_t"}, DW'(core_t), DW'(1'b0));
        check({tag, "_leds"}, DW'(leds), DW'(4'd0));
        check({tag, "_regs"}, core_x | core_e | core_m | core_r | core_r2, DW'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc; bit sr, sv;
        logic [DW-1:0] vx, vm, vr, vr2, res;
        vx = pat(32'ha426e82c); vm = pat(32'hfa4e2859); vr = pat(32'h5b18d7a7);
        vr2 = pat(32'h6106cd17); res = pat(32'h1c1f3991);

        repeat (3) @(negedge clk);
        check_cleared("reset");
        resetn = 1'b1;

        // Single load with data_valid held past the accept pulse
        load_op("ld_x", 32'd1, vx);
        check("core_x", core_x, vx);

        // Full flow
        load_op("ld_e", 32'd3, DW'(16'hd6db));
        load_op("ld_m", 32'd9, vm);
        load_op("ld_r", 32'd5, vr);
        load_op("ld_r2", 32'd7, vr2);
        check("regs_e_m", core_e ^ core_m, DW'(16'hd6db) ^ vm);
        check("regs_r_r2", core_r ^ core_r2, vr ^ vr2);
        run_compute("run16", 10'd16, res);
        check("x_kept", core_x, vx);
        exp_q.push_back(res);
        read_cmd("wr_res", 32'd2, 0);

        // Compute with t=0: no start, result register unchanged
        send_cmd(32'd0);
        wait_done("t0", 4, cyc, sr, sv);
        check("t0_lat", DW'(cyc <= 2), DW'(1'b1));
        exp_q.push_back(res);
        read_cmd("t0_res", 32'd2, 20);

        // Unknown opcode
        send_cmd(32'h3f);
        check("unk_leds", DW'(leds), DW'(4'b1101));
        wait_done("unk", 4, cyc, sr, sv);
        check("unk_no_ready", DW'(sr), DW'(1'b0));
        send_cmd(32'd0);
        check("err_clear", DW'(leds[3]), DW'(1'b0));
        wait_done("err_clr", 4, cyc, sr, sv);

        // Readback of E
`ifdef RSA_READBACK_EN
        exp_q.push_back(DW'(16'hd6db));
        read_cmd("rd_e", 32'd6, 3);
`else
        send_cmd(32'd6);
        check("rd_e_err", DW'(leds), DW'(4'b1101));
        wait_done("rd_e", 4, cyc, sr, sv);
        check("rd_e_no_valid", DW'(sv), DW'(1'b0));
`endif

        // Reset during WAITC
        t_q.push_back(10'd5);
        send_cmd({10'd5, 22'd0});
        cyc = 0;
        while (!core_start && cyc < 10) begin @(negedge clk); cyc++; end
        check("abort_core_t", DW'(core_t), (t_q.size() != 0) ? DW'(t_q.pop_front()) : DW'(11'h7ff));
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        resetn = 1'b1;
        sr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            core_done = (i == 2); core_result = res;
            @(negedge clk);
            sr |= done;
        end
        core_done = 1'b0;
        check("abort_no_done", DW'(sr), DW'(1'b0));
        exp_q.push_back(DW'(1'b0));
        read_cmd("abort_res", 32'd2, 0);

        check("sb_empty", DW'(exp_q.size() + t_q.size()), DW'(1'b0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rsa_cmd_ctrl.md
Name: rsa_cmd_ctrl

Overview:
FPGA-side responder for the ARM command/data protocol inside rsa_wrapper.
- Accepts 32-bit commands and receives 1024-bit operands into a register bank (X, E, M, R, R2).
- Starts the exponentiation core and returns the 1024-bit result to the ARM.
- Signals completion of every command with a held done/done_read handshake.

Parameters:
DATA_W, 1024, operand/result width
T_W, 10, width of the compute length field taken from cmd[31:32-T_W]

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
arm_to_fpga_cmd  in  32  command word
arm_to_fpga_cmd_valid  in  1  command strobe, sampled only in IDLE
arm_to_fpga_done  out  1  command complete, held until read
arm_to_fpga_done_read  in  1  ARM acknowledges done
arm_to_fpga_data_valid  in  1  ARM operand valid
arm_to_fpga_data_ready  out  1  one-cycle accept pulse
arm_to_fpga_data  in  DATA_W  operand
fpga_to_arm_data_valid  out  1  result valid
fpga_to_arm_data_ready  in  1  ARM ready for result
fpga_to_arm_data  out  DATA_W  result/readback data
core_x, core_e, core_m, core_r, core_r2  out  DATA_W each  operand registers to core
core_t  out  T_W  exponent bit count for the current run
core_start  out  1  one-cycle start pulse
core_done  in  1  core finished; core_result is valid in this cycle
core_result  in  DATA_W  core output
leds  out  4  {error flag, state[2:0]}

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low on resetn.
- Reset state:
  - All outputs 0; all operand registers, result register and error flag cleared; state IDLE.
  - Assertion mid-operation aborts immediately. No done is produced for the aborted command.
- States: IDLE=0, RX=1, RUN=2, WAITC=3, TX=4, DONE=5.
- Decode uses opcode = cmd[21:0]:
  - 0: COMPUTE.
  - 1, 3, 5, 7, 9: load X, E, R, R2, M respectively.
  - 2: WRITE_RESULT.
  - 4, 6, 8, 10, 12: readback X, E, M, R, R2 (see optional feature).
  - Any other value: unknown.
- IDLE:
  - Transition only on cmd_valid=1; the command is latched at that edge.
  - Load opcode -> RX. COMPUTE -> RUN. WRITE_RESULT or readback -> TX. Unknown -> DONE with error flag set.
- RX:
  - The first edge with data_valid=1 captures arm_to_fpga_data into the selected register.
  - data_ready is registered: high for exactly the next cycle. State then goes to DONE.
  - data_valid remaining high after the pulse is ignored.
- RUN:
  - If t = cmd[31:22] is 0, go to DONE without starting the core; the result register is unchanged.
  - Otherwise core_t is loaded with t, core_start=1 for one cycle, state -> WAITC.
- WAITC:
  - On core_done=1, capture core_result into the result register, then -> DONE.
  - core_done outside WAITC is ignored.
- TX:
  - fpga_to_arm_data_valid=1 with the selected data held stable.
  - Transfer happens on the edge where valid and ready are both 1. valid drops the next cycle, state -> DONE.
  - If ready is already high on entry, the transfer completes on the first TX edge.
- DONE:
  - arm_to_fpga_done=1, held until done_read=1, then -> IDLE with done=0 next cycle.
  - If done_read is already high on entry, exit after one cycle.
- Command acceptance:
  - cmd_valid outside IDLE is ignored (dropped, not queued).
  - A cmd_valid arriving in the same cycle done falls is also ignored, because state is not yet IDLE.
- Error flag: cleared by the next valid command accepted in IDLE.
- Register use: operand registers are not modified by COMPUTE and may be reloaded between runs.

Optional Feature:
- Macro: RSA_READBACK_EN.
- When defined: opcodes 4/6/8/10/12 enter TX and return X/E/M/R/R2 respectively.
- When undefined: those opcodes decode as unknown (go to DONE, error flag set, no data transfer), and the readback mux is not built.

Test Plan:
- Load X: cmd=1, data=0xa426…e82c with valid held -> data_ready pulses exactly 1 cycle, core_x matches, done=1 until done_read, then IDLE.
- Full flow:
  - Stimulus: load X=0xa426…e82c, E=0xd6db, M=0xfa4e…2859, R=0x5b18…d7a7, R2=0x6106…cd17; cmd={10'd16,22'b0}.
  - Required: core_start pulses once with core_t=16.
  - Stimulus: core model returns 0x1c1f…3991; cmd=2 with ready.
  - Required: fpga_to_arm_data=0x1c1f…3991 and done asserts.
- Compute with t=0: cmd=0 -> no core_start, done within 2 cycles, result register unchanged.
- Unknown opcode 0x3F -> done with leds[3]=1, no data_ready. Next valid command clears leds[3].
- Handshake abuse:
  - cmd_valid pulse during WAITC is ignored.
  - fpga_to_arm_data_ready held low for 20 cycles keeps valid high and data stable.
  - resetn low during WAITC clears all outputs and registers; done never asserts.
- Readback: cmd=6 -> returns 0xd6db with RSA_READBACK_EN; without the macro, error flag set and fpga_to_arm_data_valid stays 0.
